// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle for fp_addsub_seq; valid/ready on both sides.
// master = producer/consumer of operations, slave = the arithmetic unit.
interface fp_addsub_seq_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;
   logic         busy;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, flags, busy
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, flags, busy
   );
endinterface

// File: rtl/fp_addsub_seq.sv
// Sequential float add/sub, RNE rounding with DAZ/FTZ; out_valid 4+k cycles after accept (k = norm shifts).
// One operation in flight: in_ready only in IDLE, result/flags held in DONE until out_ready.
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic            clk,
   input  logic            rst,
   fp_addsub_seq_if.slave  io
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 4;
   localparam int EW = EXP_W + 1;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [EW-1:0]    EXP_INF = {1'b0, {EXP_W{1'b1}}};
   localparam logic [EXP_W:0]   FAR_SH  = (EXP_W+1)'(MAN_W + 3);
   localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic            sign_q, sign_d, eff_sub_q, eff_sub_d;
   logic [EW-1:0]   exp_q, exp_d;
   logic [SW-1:0]   l_sig_q, l_sig_d, s_sig_q, s_sig_d, mant_q, mant_d;
   logic            spec_q, spec_d, zero_q, zero_d, ftz_q, ftz_d;
   logic [W-1:0]    spec_res_q, spec_res_d, result_q, result_d;
   logic [3:0]      spec_flags_q, spec_flags_d, flags_q, flags_d;

   // b_q already carries the effective sign (op folded in at accept)
   logic               sa, sb;
   logic [EXP_W-1:0]   ea, eb;
   logic [MAN_W-1:0]   ma, mb;
   logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
   assign {sa, ea, ma} = a_q;
   assign {sb, eb, mb} = b_q;
   assign a_nan  = (ea == EXP_MAX) && (ma != '0);
   assign b_nan  = (eb == EXP_MAX) && (mb != '0);
   assign a_snan = a_nan && !ma[MAN_W-1];
   assign b_snan = b_nan && !mb[MAN_W-1];
   assign a_inf  = (ea == EXP_MAX) && (ma == '0);
   assign b_inf  = (eb == EXP_MAX) && (mb == '0);
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);

   logic               swap, sl, ss;
   logic [EXP_W-1:0]   el, es, diff;
   logic [MAN_W-1:0]   ml, ms;
   logic [SW-1:0]      l_al, s_ext, s_al, lost;
   logic               sp;
   logic [W-1:0]       sp_res;
   logic [3:0]         sp_flags;

   always_comb begin
      swap   = b_q[W-2:0] > a_q[W-2:0];
      sl     = swap ? sb : sa;
      ss     = swap ? sa : sb;
      el     = swap ? eb : ea;
      es     = swap ? ea : eb;
      ml     = swap ? mb : ma;
      ms     = swap ? ma : mb;
      diff   = el - es;
      l_al   = {1'b1, ml, 3'b000};
      s_ext  = {1'b1, ms, 3'b000};
      s_al   = s_ext >> diff;
      lost   = s_ext & ~({SW{1'b1}} << diff);
      if ({1'b0, diff} >= FAR_SH) begin
         s_al = {{(SW-1){1'b0}}, 1'b1};
      end else begin
         s_al[0] = s_al[0] | (|lost);
      end

      sp       = 1'b1;
      sp_res   = '0;
      sp_flags = '0;
      if (a_nan || b_nan) begin
         sp_res   = QNAN;
         sp_flags = {a_snan | b_snan, 3'b000};
      end else if (a_inf && b_inf) begin
         if (sa != sb) begin
            sp_res   = QNAN;
            sp_flags = 4'b1000;
         end else begin
            sp_res = a_q;
         end
      end else if (a_inf) begin
         sp_res = a_q;
      end else if (b_inf) begin
         sp_res = b_q;
      end else if (a_zero && b_zero) begin
         sp_res = {sa & sb, {(W-1){1'b0}}};
      end else if (a_zero) begin
         sp_res = b_q;
      end else if (b_zero) begin
         sp_res = a_q;
      end else begin
         sp = 1'b0;
      end
   end

   logic [SW:0] sum;
   assign sum = eff_sub_q ? ({1'b0, l_sig_q} - {1'b0, s_sig_q})
                          : ({1'b0, l_sig_q} + {1'b0, s_sig_q});

   logic               g, r, st, lsb;
   logic [MAN_W+1:0]   rnd;
   logic [EW-1:0]      exp_r;
   logic [MAN_W-1:0]   man_r;
   logic [W-1:0]       rnd_res;
   logic [3:0]         rnd_flags;

   always_comb begin
      lsb       = mant_q[3];
      g         = mant_q[2];
      r         = mant_q[1];
      st        = mant_q[0];
      rnd       = {1'b0, mant_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, g & (r | st | lsb)};
      exp_r     = exp_q + {{EXP_W{1'b0}}, rnd[MAN_W+1]};
      man_r     = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
      rnd_res   = {sign_q, exp_r[EXP_W-1:0], man_r};
      rnd_flags = {3'b000, g | r | st};
      if (spec_q) begin
         rnd_res   = spec_res_q;
         rnd_flags = spec_flags_q;
      end else if (zero_q) begin
         rnd_res   = {sign_q, {(W-1){1'b0}}};
         rnd_flags = 4'b0000;
      end else if (ftz_q) begin
         rnd_res   = {sign_q, {(W-1){1'b0}}};
         rnd_flags = 4'b0011;
      end else if (exp_r >= EXP_INF) begin
         rnd_res   = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
         rnd_flags = 4'b0101;
      end
   end

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      sign_d       = sign_q;
      eff_sub_d    = eff_sub_q;
      exp_d        = exp_q;
      l_sig_d      = l_sig_q;
      s_sig_d      = s_sig_q;
      mant_d       = mant_q;
      spec_d       = spec_q;
      zero_d       = zero_q;
      ftz_d        = ftz_q;
      spec_res_d   = spec_res_q;
      spec_flags_d = spec_flags_q;
      result_d     = result_q;
      flags_d      = flags_q;
      case (state_q)
         S_IDLE: begin
            if (io.in_valid) begin
               a_d     = io.a;
               b_d     = {io.b[W-1] ^ io.op, io.b[W-2:0]};
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            sign_d       = sl;
            eff_sub_d    = sl ^ ss;
            exp_d        = {1'b0, el};
            l_sig_d      = l_al;
            s_sig_d      = s_al;
            spec_d       = sp;
            spec_res_d   = sp_res;
            spec_flags_d = sp_flags;
            zero_d       = 1'b0;
            ftz_d        = 1'b0;
            state_d      = S_ADD;
         end
         S_ADD: begin
            mant_d = sum[SW-1:0];
            if (sum == '0) begin
               zero_d = 1'b1;
               sign_d = 1'b0;
            end else if (sum[SW]) begin
               mant_d = {sum[SW:2], sum[1] | sum[0]};
               exp_d  = exp_q + 1'b1;
            end
            state_d = S_NORM;
         end
         S_NORM: begin
            if (spec_q || zero_q || mant_q[SW-1]) begin
               state_d = S_ROUND;
            end else if (exp_q > EW'(1)) begin
               mant_d = mant_q << 1;
               exp_d  = exp_q - 1'b1;
            end else begin
               ftz_d   = 1'b1;
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            result_d = rnd_res;
            flags_d  = rnd_flags;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (io.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q          <= '0;
         b_q          <= '0;
         sign_q       <= 1'b0;
         eff_sub_q    <= 1'b0;
         exp_q        <= '0;
         l_sig_q      <= '0;
         s_sig_q      <= '0;
         mant_q       <= '0;
         spec_q       <= 1'b0;
         zero_q       <= 1'b0;
         ftz_q        <= 1'b0;
         spec_res_q   <= '0;
         spec_flags_q <= '0;
         result_q     <= '0;
         flags_q      <= '0;
      end else begin
         a_q          <= a_d;
         b_q          <= b_d;
         sign_q       <= sign_d;
         eff_sub_q    <= eff_sub_d;
         exp_q        <= exp_d;
         l_sig_q      <= l_sig_d;
         s_sig_q      <= s_sig_d;
         mant_q       <= mant_d;
         spec_q       <= spec_d;
         zero_q       <= zero_d;
         ftz_q        <= ftz_d;
         spec_res_q   <= spec_res_d;
         spec_flags_q <= spec_flags_d;
         result_q     <= result_d;
         flags_q      <= flags_d;
      end
   end

   assign io.in_ready  = (state_q == S_IDLE);
   assign io.busy      = (state_q != S_IDLE);
   assign io.out_valid = (state_q == S_DONE);
   assign io.result    = result_q;
   assign io.flags     = flags_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed-vector bench for fp_addsub_seq (single precision): results, flags, latency,
// backpressure and asynchronous reset behaviour against hand-computed values.
module tb_fp_addsub_seq;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   fp_addsub_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
   fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.clk(clk), .rst(rst), .io(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one operation, scrambles the inputs while busy, waits (bounded) for out_valid.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        output logic [31:0] res, output logic [3:0] flg, output int lat);
      bus.a        = a;
      bus.b        = b;
      bus.op       = op;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = 32'hDEADBEEF;
      bus.b        = 32'h12345678;
      bus.op       = ~op;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      res = bus.result;
      flg = bus.flags;
   endtask

   task automatic release_out();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL rst_result: got %h want 00000000", bus.result); end
      n_vec++; if (bus.flags !== 4'h0) begin n_err++; $display("FAIL rst_flags: got %b want 0000", bus.flags); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_sub_latency();
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
      do_op(32'h40400000, 32'h3F800000, 1'b1, res, flg, lat);
      n_vec++; if (res !== 32'h40000000) begin n_err++; $display("FAIL sub3m1_result: got %h want 40000000", res); end
      n_vec++; if (flg !== 4'b0000) begin n_err++; $display("FAIL sub3m1_flags: got %b want 0000", flg); end
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL sub3m1_latency: got %0d want 4", lat); end
      release_out();
      do_op(32'h3F800000, 32'h3F400000, 1'b1, res, flg, lat);
      n_vec++; if (res !== 32'h3E800000) begin n_err++; $display("FAIL sub1m075_result: got %h want 3e800000", res); end
      n_vec++; if (flg !== 4'b0000) begin n_err++; $display("FAIL sub1m075_flags: got %b want 0000", flg); end
      n_vec++; if (lat !== 6) begin n_err++; $display("FAIL sub1m075_latency: got %0d want 6", lat); end
      release_out();
   endtask

   task automatic test_rounding();
      logic [31:0] va [4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
      logic [31:0] vb [4] = '{32'h33800000, 32'h3F800000, 32'h34400000, 32'h30800000};
      logic [31:0] vr [4] = '{32'h3F800000, 32'h40000000, 32'h3F800002, 32'h3F800000};
      logic [3:0]  vf [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001};
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vb[i], 1'b0, res, flg, lat);
         n_vec++; if (res !== vr[i]) begin n_err++; $display("FAIL round%0d_result: got %h want %h", i, res, vr[i]); end
         n_vec++; if (flg !== vf[i]) begin n_err++; $display("FAIL round%0d_flags: got %b want %b", i, flg, vf[i]); end
         release_out();
      end
   endtask

   task automatic test_specials();
      logic [31:0] va [10] = '{32'h7F800000, 32'h7F7FFFFF, 32'h80000000, 32'h7F800001, 32'h7FC00001,
                              32'h00000000, 32'h3F800000, 32'hFF800000, 32'h3F800000, 32'h00800001};
      logic [31:0] vb [10] = '{32'h7F800000, 32'h7F7FFFFF, 32'h80000000, 32'h3F800000, 32'h3F800000,
                              32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00800000};
      logic        vo [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] vr [10] = '{32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h7FC00000, 32'h7FC00000,
                              32'hBF800000, 32'h00000000, 32'hFF800000, 32'h3F800000, 32'h00000000};
      logic [3:0]  vf [10] = '{4'b1000, 4'b0101, 4'b0000, 4'b1000, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
      for (int i = 0; i < 10; i++) begin
         do_op(va[i], vb[i], vo[i], res, flg, lat);
         n_vec++; if (res !== vr[i]) begin n_err++; $display("FAIL spec%0d_result: got %h want %h", i, res, vr[i]); end
         n_vec++; if (flg !== vf[i]) begin n_err++; $display("FAIL spec%0d_flags: got %b want %b", i, flg, vf[i]); end
         n_vec++; if (lat !== 4) begin n_err++; $display("FAIL spec%0d_latency: got %0d want 4", i, lat); end
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
      do_op(32'h3F800000, 32'h3F800000, 1'b0, res, flg, lat);
      n_vec++; if (res !== 32'h40000000) begin n_err++; $display("FAIL bp_result: got %h want 40000000", res); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, bus.out_valid); end
         n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready%0d: got %b want 0", i, bus.in_ready); end
         n_vec++; if (bus.result !== 32'h40000000) begin n_err++; $display("FAIL bp_hold_result%0d: got %h want 40000000", i, bus.result); end
         n_vec++; if (bus.flags !== 4'b0000) begin n_err++; $display("FAIL bp_hold_flags%0d: got %b want 0000", i, bus.flags); end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
      do_op(32'h40400000, 32'h3F800000, 1'b1, res, flg, lat);
      n_vec++; if (res !== 32'h40000000) begin n_err++; $display("FAIL b2b_result: got %h want 40000000", res); end
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d want 4", lat); end
      release_out();
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
      bus.a        = 32'h3F800000;
      bus.b        = 32'h3F400000;
      bus.op       = 1'b1;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
      rst = 1'b1;
      #1;
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
      n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL midrst_result: got %h want 00000000", bus.result); end
      tick();
      rst = 1'b0;
      tick();
      do_op(32'h40400000, 32'h3F800000, 1'b1, res, flg, lat);
      n_vec++; if (res !== 32'h40000000) begin n_err++; $display("FAIL postrst_result: got %h want 40000000", res); end
      n_vec++; if (flg !== 4'b0000) begin n_err++; $display("FAIL postrst_flags: got %b want 0000", flg); end
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL postrst_latency: got %0d want 4", lat); end
      release_out();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = 1'b0;
      test_reset();
      test_sub_latency();
      test_rounding();
      test_specials();
      test_back_to_back();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
Sequential, parametrised IEEE-754-style floating-point add/subtract unit for the team's arithmetic library. It is the successor to the combinational single-precision subtractor.
- Exponent and mantissa widths are generic; add or subtract is selected per operation.
- Rounding is round-to-nearest-even, with correct special-value handling and exception flags.
- One operation is in flight at a time. Input and output use valid/ready handshakes.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa field width (hidden bit implied); word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands a, b, op presented
in_ready  out  1  unit can accept; high only in IDLE
a  in  W  operand A {sign, exp, man}
b  in  W  operand B
op  in  1  0 = a+b, 1 = a-b
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  W  rounded result
flags  out  4  {invalid, overflow, underflow, inexact}
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, out_valid=0, result=0, flags=0, busy=0, in_ready=1. Any in-flight operation is discarded; no partial output appears.
- Accept: an operation is accepted on the edge where in_valid && in_ready. a, b, op are registered, and op=1 inverts b's sign.
- States: IDLE → ALIGN → ADD → NORM (1..n cycles) → ROUND → DONE → IDLE.
- Latency: out_valid rises 4+k edges after the accept edge, where k = number of NORM left shifts. k=0 for specials, carry, or already-normalised sums.
- ALIGN:
  - Unpack and restore the hidden bit.
  - Subnormal inputs are treated as zero (DAZ).
  - Swap so the larger magnitude (exponent, then mantissa) is operand L.
  - Right-shift the smaller mantissa by the exponent difference. Keep guard and round bits; OR all shifted-out bits into sticky.
  - A difference ≥ MAN_W+3 reduces the smaller operand to sticky only.
- ADD:
  - Equal effective signs: add magnitudes. Otherwise: L minus smaller; result sign is L's sign.
  - Carry-out: shift right 1 (LSB folds into sticky), exp+1.
- NORM:
  - Each cycle: if the MSB is 0, mantissa != 0, and exp > 1, shift left 1 and exp−1.
  - Otherwise go to ROUND.
  - If the MSB is still 0 when exp == 1, flush to zero (FTZ), set underflow and inexact.
- ROUND:
  - RNE on guard/round/sticky. A round-up carry renormalises (exp+1).
  - inexact = any of guard/round/sticky set.
  - exp ≥ 2^EXP_W−1 after rounding → ±inf, with overflow and inexact set.
- Zero results:
  - Exact zero from a difference → +0.
  - (−0)+(−0) → −0.
  - x−x → +0.
- Specials (detected at ALIGN; bypass arithmetic, k=0):
  - Either operand NaN → canonical qNaN {0, all-ones exp, 1, zeros}. invalid is set only if the input was an sNaN.
  - inf − inf (effective subtraction) → canonical qNaN, invalid=1.
  - inf ± finite → that inf.
  - Zero ± x → x exactly, with flags 0.
- DONE:
  - out_valid=1. result and flags are held stable while !out_ready.
  - Leaves to IDLE on the edge where out_ready=1; out_valid drops the same edge.
  - in_ready stays 0 until IDLE, so there is no accept/complete overlap.
- Inputs changing while busy are ignored.
- Simultaneous rst and handshake: reset wins.

Test Plan:
1. 3.0 − 1.0: a=0x40400000, b=0x3F800000, op=1 → result 0x40000000, flags 0000, out_valid 4 edges after accept (k=0).
2. 1.0 − 0.75: a=0x3F800000, b=0x3F400000, op=1 → result 0x3E800000, flags 0000, out_valid 6 edges after accept (k=2).
3. Rounding tie and carry:
   - 1.0 + 2^-24: a=0x3F800000, b=0x33800000, op=0 → result 0x3F800000, inexact=1.
   - 1.0 + 1.0 → result 0x40000000, flags 0000.
4. Specials:
   - 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1.
   - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
   - 0x80000000 + 0x80000000 → 0x80000000.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE → result and flags stable, in_ready=0 throughout. Raise out_ready → out_valid=0 and in_ready=1 on the next edge; a back-to-back second operation is accepted.
6. Reset mid-operation: assert rst during NORM of test 2 → out_valid=0, busy=0, in_ready=1 immediately. After deassert, test 1 completes with correct result and latency.
